// File: rtl/flit_link_tx.sv
// flit_link_tx: serializes types::flit_t flits into PHIT_W-bit phits, LSB first, under credit flow control.
// Optional per-phit even parity is compiled in by defining FLIT_LINK_TX_PARITY_EN.
package types;
   typedef struct packed {
      logic [1:0]  kind;
      logic [3:0]  dest;
      logic [31:0] payload;
   } flit_t;
endpackage

module flit_link_tx #(
   parameter  int PHIT_W    = 8,
   parameter  int CREDITS   = 8,
   localparam int FLIT_W    = $bits(types::flit_t),
   localparam int NUM_PHITS = (FLIT_W + PHIT_W - 1) / PHIT_W,
   localparam int CW        = $clog2(CREDITS + 1)
) (
   input  logic              nocclk,
   input  logic              rst_n,
   input  logic              forwarded_flit_valid,
   output logic              forwarded_flit_ready,
   input  types::flit_t      forwarded_flit,
   output logic              phit_valid,
   output logic              phit_first,
   output logic              phit_last,
   output logic [PHIT_W-1:0] phit_data,
   output logic              phit_parity,
   input  logic              credit_return,
   output logic [CW-1:0]     credit_count,
   output logic              credit_overflow,
   output logic              idle
);

   localparam int            SR_W        = NUM_PHITS * PHIT_W;
   localparam int            IW          = (NUM_PHITS > 1) ? $clog2(NUM_PHITS) : 1;
   localparam logic [IW-1:0] LAST_IDX    = IW'(NUM_PHITS - 1);
   localparam logic [CW-1:0] MAX_CREDITS = CW'(CREDITS);

   typedef enum logic {IDLE, SEND} state_t;

   state_t            state, next_state;
   logic [IW-1:0]     idx, next_idx;
   logic [SR_W-1:0]   shreg, next_shreg;
   logic [SR_W-1:0]   flit_ext;
   logic              next_valid, next_first, next_last;
   logic [PHIT_W-1:0] next_data;
   logic              at_last;
   logic              accept;

   // idx names the phit currently on the link, so the last phit cycle can already take the next flit
   assign at_last              = (state == SEND) && (idx == LAST_IDX);
   assign forwarded_flit_ready = ((state == IDLE) || at_last) && (credit_count != '0);
   assign accept               = forwarded_flit_valid && forwarded_flit_ready;
   assign idle                 = (state == IDLE) && (credit_count == MAX_CREDITS);

   always_comb begin
      flit_ext               = '0;
      flit_ext[FLIT_W-1:0]   = forwarded_flit;
   end

   always_comb begin
      next_state = state;
      next_idx   = idx;
      next_shreg = shreg;
      next_valid = 1'b0;
      next_first = 1'b0;
      next_last  = 1'b0;
      next_data  = '0;
      if (accept) begin
         next_state = SEND;
         next_idx   = '0;
         next_shreg = flit_ext >> PHIT_W;
         next_valid = 1'b1;
         next_first = 1'b1;
         next_last  = (LAST_IDX == '0);
         next_data  = flit_ext[PHIT_W-1:0];
      end else if (state == SEND) begin
         if (at_last) begin
            next_state = IDLE;
         end else begin
            next_idx   = idx + IW'(1);
            next_shreg = shreg >> PHIT_W;
            next_valid = 1'b1;
            next_last  = ((idx + IW'(1)) == LAST_IDX);
            next_data  = shreg[PHIT_W-1:0];
         end
      end
   end

   always_ff @(posedge nocclk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         idx        <= '0;
         shreg      <= '0;
         phit_valid <= 1'b0;
         phit_first <= 1'b0;
         phit_last  <= 1'b0;
         phit_data  <= '0;
      end else begin
         state      <= next_state;
         idx        <= next_idx;
         shreg      <= next_shreg;
         phit_valid <= next_valid;
         phit_first <= next_first;
         phit_last  <= next_last;
         phit_data  <= next_data;
      end
   end

`ifdef FLIT_LINK_TX_PARITY_EN
   always_ff @(posedge nocclk or negedge rst_n) begin
      if (!rst_n) begin
         phit_parity <= 1'b0;
      end else begin
         phit_parity <= ^next_data;
      end
   end
`else
   assign phit_parity = 1'b0;
`endif

   // A return that coincides with an acceptance cancels out, so overflow is only flagged when nothing is spent
   always_ff @(posedge nocclk or negedge rst_n) begin
      if (!rst_n) begin
         credit_count    <= MAX_CREDITS;
         credit_overflow <= 1'b0;
      end else begin
         if (accept && !credit_return) begin
            credit_count <= credit_count - CW'(1);
         end else if (!accept && credit_return) begin
            if (credit_count == MAX_CREDITS) begin
               credit_overflow <= 1'b1;
            end else begin
               credit_count <= credit_count + CW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_flit_link_tx.sv
// tb_flit_link_tx: directed bench for flit_link_tx with a phit scoreboard and a credit/ready model.
module tb_flit_link_tx;

   localparam int PHIT_W    = 8;
   localparam int CREDITS   = 8;
   localparam int FLIT_W    = $bits(types::flit_t);
   localparam int NUM_PHITS = (FLIT_W + PHIT_W - 1) / PHIT_W;
   localparam int CW        = $clog2(CREDITS + 1);
`ifdef FLIT_LINK_TX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic              nocclk;
   logic              rst_n;
   logic              forwarded_flit_valid;
   logic              forwarded_flit_ready;
   types::flit_t      forwarded_flit;
   logic              phit_valid;
   logic              phit_first;
   logic              phit_last;
   logic [PHIT_W-1:0] phit_data;
   logic              phit_parity;
   logic              credit_return;
   logic [CW-1:0]     credit_count;
   logic              credit_overflow;
   logic              idle;

   typedef struct {
      int                due;
      logic [PHIT_W-1:0] data;
      logic              first;
      logic              last;
      logic              parity;
   } exp_t;

   exp_t sb_q[$];
   int   checks     = 0;
   int   failures   = 0;
   int   cyc        = 0;
   int   m_credits  = CREDITS;
   int   m_last_due = -10;
   logic m_overflow = 1'b0;

   flit_link_tx #(.PHIT_W(PHIT_W), .CREDITS(CREDITS)) dut (
      .nocclk               (nocclk),
      .rst_n                (rst_n),
      .forwarded_flit_valid (forwarded_flit_valid),
      .forwarded_flit_ready (forwarded_flit_ready),
      .forwarded_flit       (forwarded_flit),
      .phit_valid           (phit_valid),
      .phit_first           (phit_first),
      .phit_last            (phit_last),
      .phit_data            (phit_data),
      .phit_parity          (phit_parity),
      .credit_return        (credit_return),
      .credit_count         (credit_count),
      .credit_overflow      (credit_overflow),
      .idle                 (idle)
   );

   initial nocclk = 1'b0;
   always #5 nocclk = ~nocclk;

   always @(posedge nocclk) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic types::flit_t flit_bytes(input logic [63:0] b);
      return types::flit_t'(b[FLIT_W-1:0]);
   endfunction

   function automatic types::flit_t rand_flit();
      logic [63:0] r;
      r = {$urandom, $urandom};
      return types::flit_t'(r[FLIT_W-1:0]);
   endfunction

   // Phits due in this cycle must be on the link; any other cycle must show no phit
   always @(negedge nocclk) begin
      exp_t e;
      if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
         e = sb_q.pop_front();
         checkOutput("phit_valid", 64'(phit_valid), 64'(1'b1));
         checkOutput("phit_data", 64'(phit_data), 64'(e.data));
         checkOutput("phit_first", 64'(phit_first), 64'(e.first));
         checkOutput("phit_last", 64'(phit_last), 64'(e.last));
         checkOutput("phit_parity", 64'(phit_parity), 64'(e.parity));
      end else begin
         checkOutput("phit_valid_gap", 64'(phit_valid), 64'(1'b0));
      end
   end

   // One cycle: check registered state against the model, then drive inputs for the coming edge
   task automatic applyStimulus(input logic v, input types::flit_t f, input logic cr);
      logic                        m_ready;
      logic                        acc;
      logic [NUM_PHITS*PHIT_W-1:0] padded;
      exp_t                        e;
      @(posedge nocclk);
      #1;
      checkOutput("credit_count", 64'(credit_count), 64'(m_credits));
      checkOutput("credit_overflow", 64'(credit_overflow), 64'(m_overflow));
      checkOutput("idle", 64'(idle), 64'((m_last_due < cyc) && (m_credits == CREDITS)));
      m_ready = (m_last_due <= cyc) && (m_credits != 0);
      checkOutput("ready", 64'(forwarded_flit_ready), 64'(m_ready));
      forwarded_flit_valid = v;
      forwarded_flit       = f;
      credit_return        = cr;
      acc = v && m_ready && rst_n;
      if (acc) begin
         padded             = '0;
         padded[FLIT_W-1:0] = f;
         for (int k = 0; k < NUM_PHITS; k++) begin
            e.due    = cyc + 1 + k;
            e.data   = padded[k*PHIT_W +: PHIT_W];
            e.first  = (k == 0);
            e.last   = (k == NUM_PHITS - 1);
            e.parity = PAR_EN ? ^e.data : 1'b0;
            sb_q.push_back(e);
         end
         m_last_due = cyc + NUM_PHITS;
      end
      if (rst_n) begin
         if (acc && !cr) begin
            m_credits--;
         end else if (!acc && cr) begin
            if (m_credits == CREDITS) m_overflow = 1'b1;
            else m_credits++;
         end
      end
   endtask

   task automatic drain(input int n);
      repeat (n) applyStimulus(1'b0, '0, 1'b0);
   endtask

   task automatic returnCredits(input int n);
      repeat (n) applyStimulus(1'b0, '0, 1'b1);
   endtask

   task automatic checkResetValues();
      checkOutput("rst_phit_valid", 64'(phit_valid), 64'(0));
      checkOutput("rst_phit_first", 64'(phit_first), 64'(0));
      checkOutput("rst_phit_last", 64'(phit_last), 64'(0));
      checkOutput("rst_phit_data", 64'(phit_data), 64'(0));
      checkOutput("rst_phit_parity", 64'(phit_parity), 64'(0));
      checkOutput("rst_overflow", 64'(credit_overflow), 64'(0));
      checkOutput("rst_credit_count", 64'(credit_count), 64'(CREDITS));
      checkOutput("rst_ready", 64'(forwarded_flit_ready), 64'(1));
      checkOutput("rst_idle", 64'(idle), 64'(1));
   endtask

   initial begin
      rst_n                = 1'b0;
      forwarded_flit_valid = 1'b0;
      forwarded_flit       = '0;
      credit_return        = 1'b0;
      #12;
      checkResetValues();
      #10;
      rst_n = 1'b1;
      $display("[TB] reset released");

      // Single flit whose byte i is i; last phit carries only the low FLIT_W bits
      applyStimulus(1'b1, flit_bytes(64'h04_03_02_01_00), 1'b0);
      drain(NUM_PHITS + 2);

      // Credit return in the acceptance cycle leaves the count unchanged
      applyStimulus(1'b1, rand_flit(), 1'b1);
      drain(NUM_PHITS + 2);
      returnCredits(1);

      $display("[TB] back-to-back flits");
      repeat (3 * NUM_PHITS) applyStimulus(1'b1, rand_flit(), 1'b0);
      drain(NUM_PHITS + 2);
      returnCredits(3);

      // Phit 0x07 has odd weight, phit 0x03 even weight
      applyStimulus(1'b1, flit_bytes(64'h00_00_00_03_07), 1'b0);
      drain(NUM_PHITS + 2);
      returnCredits(1);

      // All-ones flit exposes the zero padding of the last phit
      applyStimulus(1'b1, flit_bytes('1), 1'b0);
      drain(NUM_PHITS + 2);
      returnCredits(1);

      $display("[TB] credit exhaustion");
      repeat (CREDITS * NUM_PHITS + 4) applyStimulus(1'b1, rand_flit(), 1'b0);
      applyStimulus(1'b1, rand_flit(), 1'b1);
      applyStimulus(1'b1, rand_flit(), 1'b0);
      drain(NUM_PHITS + 2);
      returnCredits(CREDITS);

      $display("[TB] credit overflow");
      applyStimulus(1'b0, '0, 1'b1);
      drain(3);

      $display("[TB] reset mid-flit");
      applyStimulus(1'b1, rand_flit(), 1'b0);
      drain(2);
      #1;
      rst_n                = 1'b0;
      forwarded_flit_valid = 1'b0;
      credit_return        = 1'b0;
      #1;
      checkResetValues();
      sb_q.delete();
      m_credits  = CREDITS;
      m_overflow = 1'b0;
      m_last_due = -10;
      drain(2);
      #2;
      rst_n = 1'b1;
      applyStimulus(1'b1, rand_flit(), 1'b0);
      drain(NUM_PHITS + 2);

      checkOutput("scoreboard_empty", 64'(sb_q.size()), 64'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/flit_link_tx.md
# flit_link_tx

- Transmit end of the inter-device flit link.
- Takes the `forwarded_flit` stream leaving `packet_controller` and serializes each `types::flit_t` into `PHIT_W`-bit phits on a narrow physical link.
- Flow control is credit-based, matched to the receiving device's packet buffer depth.
- Feeds the link deserializer that presents `next_flit` to the neighbouring node's `packet_controller`.

## Interface

Parameters:
- `PHIT_W`, 8: phit data width in bits; must be ≥1.
- `CREDITS`, 8: initial and maximum credit count; equals the remote `PACKET_BUFFER_NUM_ENTRIES`.
- Derived: `FLIT_W = $bits(types::flit_t)`, `NUM_PHITS = (FLIT_W+PHIT_W-1)/PHIT_W`, `CW = $clog2(CREDITS+1)`.

Ports:
- `nocclk`  in  1  clock; single clock domain.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `forwarded_flit_valid`  in  1  upstream flit valid.
- `forwarded_flit_ready`  out  1  block accepts flit this cycle.
- `forwarded_flit`  in  `types::flit_t`  flit to transmit.
- `phit_valid`  out  1  phit on link this cycle.
- `phit_first`  out  1  phit 0 of a flit.
- `phit_last`  out  1  phit `NUM_PHITS-1` of a flit.
- `phit_data`  out  `PHIT_W`  phit payload.
- `phit_parity`  out  1  even parity of `phit_data` (see Configuration).
- `credit_return`  in  1  one-cycle pulse, one remote buffer entry freed.
- `credit_count`  out  `CW`  credits currently held.
- `credit_overflow`  out  1  sticky error: credit returned while count == `CREDITS`.
- `idle`  out  1  state IDLE and `credit_count == CREDITS`.

## Operation

- FSM states: IDLE and SEND.
- Phit index counter `idx` runs 0..`NUM_PHITS-1`.
- Flit shift register: `NUM_PHITS*PHIT_W` bits. The flit is zero-extended into it, so the last phit's high bits are 0 when `FLIT_W` is not a multiple of `PHIT_W`.
- `forwarded_flit_ready = (IDLE || (SEND && idx == NUM_PHITS-1)) && credit_count != 0`. This is combinational from registered state only; it never depends on `forwarded_flit_valid`.
- Acceptance (`valid && ready`):
  - Load the shift register.
  - Consume one credit.
  - Go to SEND with `idx = 0`.
- SEND, per cycle:
  - Drive phit `idx` with LSB-first ordering: phit k = flit bits [k*PHIT_W +: PHIT_W].
  - Increment `idx`.
  - At `idx == NUM_PHITS-1`: with no new acceptance go to IDLE; with an acceptance, restart at `idx = 0` with the new flit.
- The link has no stall. Once phit 0 is emitted, all phits of that flit are emitted on consecutive cycles.
- Credits:
  - Counter is decremented on acceptance and incremented on `credit_return`.
  - Both in the same cycle: unchanged.
  - `credit_return` at `credit_count == CREDITS`, with no acceptance that cycle: increment suppressed, `credit_overflow` set until reset.
  - `credit_count` never underflows, because ready requires nonzero credit.
- `NUM_PHITS == 1`: every phit asserts both `phit_first` and `phit_last`, and ready may be high every cycle.

## Timing

- All link outputs are registered.
- Flit accepted at edge T: phit 0 appears in cycle T+1, and phit k in cycle T+1+k.
- Sustained throughput: one flit per `NUM_PHITS` cycles when credits are available.
- Phit streams of back-to-back flits have no gap cycle.
- `credit_count` reflects an acceptance or return in the cycle after the edge.
- Reset values:
  - `phit_valid`, `phit_first`, `phit_last`, `phit_data`, `phit_parity`, `credit_overflow` = 0.
  - `credit_count = CREDITS`; state IDLE; `idle` = 1.
  - `forwarded_flit_ready` = 1.
- Reset mid-flit:
  - The partial flit is abandoned.
  - Outputs drop to reset values asynchronously.
  - The remote side is assumed to be reset simultaneously.

## Configuration

- `FLIT_LINK_TX_PARITY_EN`: compiled in adds per-phit even parity; compiled out removes it.

| | `phit_parity` | Timing |
|---|---|---|
| Defined | `^phit_data`, registered with the phit | Same cycle as its phit |
| Undefined | Tied to 0 | Port list and timing unchanged |

## Test plan

- **Reset:** assert `rst_n=0` mid-SEND → all outputs 0 immediately; after release, `credit_count=CREDITS`, ready=1, `idle`=1.
- **Single flit, `PHIT_W=8`:** flit whose byte i = i → phits 0,1,2,… on consecutive cycles starting T+1.
  - `phit_first` set only on phit 0; `phit_last` set only on phit `NUM_PHITS-1`.
  - Last phit zero-padded.
  - `credit_count` goes 8→7.
- **Back-to-back:** `valid` held high for 3 flits with credits available → `3*NUM_PHITS` contiguous `phit_valid` cycles, no gap; `credit_count` 8→5.
- **Credit exhaustion:**
  - 8 flits with no `credit_return` → ready=0 after the 8th acceptance, `credit_count`=0, no 9th flit accepted.
  - One `credit_return` pulse → ready=1 next cycle, 9th flit sent.
- **Simultaneous:** `credit_return` in the acceptance cycle → `credit_count` unchanged.
- **Overflow:** `credit_return` at `credit_count=8` → count stays 8, `credit_overflow`=1 and sticky.
- **Parity, `FLIT_LINK_TX_PARITY_EN` defined:** phit 0x07 → `phit_parity`=1; phit 0x03 → `phit_parity`=0. Undefined: always 0.
